// File: rtl/mpu_cmd_scheduler.sv
// mpu_cmd_scheduler: in-order command FIFO feeding the MPU controller.
// Each command is issued with a one-cycle start pulse. Issue is held off while
// the head command reads or overwrites a register whose result is still
// waiting for collector write-back.
module mpu_cmd_scheduler #(
  parameter int ADDR_W     = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int PEND_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid_in,
  output logic                            cmd_ready_out,
  input  logic [ADDR_W-1:0]               cmd_src0_in,
  input  logic [ADDR_W-1:0]               cmd_src1_in,
  input  logic [ADDR_W-1:0]               cmd_dest_in,
  output logic                            start_mult_out,
  output logic [ADDR_W-1:0]               src_addr_0_out,
  output logic [ADDR_W-1:0]               src_addr_1_out,
  output logic [ADDR_W-1:0]               dest_addr_out,
  input  logic                            disp_finished_in,
  input  logic                            coll_done_in,
  output logic                            busy_out,
  output logic [$clog2(FIFO_DEPTH):0]     queue_count_out,
  output logic                            hazard_stall_out,
  output logic                            err_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 3 * ADDR_W;

  typedef enum logic [1:0] {D_IDLE, D_ISSUE, D_BUSY} dstate_t;

  // FIFO storage and bookkeeping
  logic [ENT_W-1:0]  fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;

  // Dispatch state and issued addresses
  dstate_t           state_q, state_d;
  logic [ADDR_W-1:0] src0_q, src1_q, dest_q;

  // Pending write-back list; entry 0 is the oldest
  logic [ADDR_W-1:0] pend0_q, pend1_q, pend0_d, pend1_d;
  logic [1:0]        pend_cnt_q, pend_cnt_d;

  logic              err_q, err_d;

  logic              fifo_full, fifo_empty, push, issue;
  logic [ENT_W-1:0]  head;
  logic [ADDR_W-1:0] head_src0, head_src1, head_dest;
  logic              pend_v0, pend_v1, pend_room, hazard;
  logic              pend_push, pend_pop;

  assign fifo_full  = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt_q == '0);
  assign push       = cmd_valid_in && !fifo_full;
  assign head       = fifo_mem_q[rd_ptr_q];
  assign head_src0  = head[3*ADDR_W-1:2*ADDR_W];
  assign head_src1  = head[2*ADDR_W-1:ADDR_W];
  assign head_dest  = head[ADDR_W-1:0];

  assign pend_v0   = (pend_cnt_q != 2'd0);
  assign pend_v1   = (pend_cnt_q == 2'd2);
  assign pend_room = (pend_cnt_q < 2'(PEND_DEPTH));

  // RAW on either source or WAW on the destination against any live pending dest
  assign hazard = (pend_v0 && (head_src0 == pend0_q || head_src1 == pend0_q || head_dest == pend0_q)) ||
                  (pend_v1 && (head_src0 == pend1_q || head_src1 == pend1_q || head_dest == pend1_q));

  // Dispatch next-state: issue the head when room exists and no hazard blocks it
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      D_IDLE: begin
        if (!fifo_empty && pend_room && !hazard) begin
          state_d = D_ISSUE;
          issue   = 1'b1;
        end
      end
      D_ISSUE: state_d = D_BUSY;
      D_BUSY:  if (disp_finished_in) state_d = D_IDLE;
      default: state_d = D_IDLE;
    endcase
  end

  // Pending list update: pop oldest first, then append the finishing dest behind it
  always_comb begin
    pend_push  = disp_finished_in && (state_q == D_BUSY);
    pend_pop   = coll_done_in && pend_v0;
    pend0_d    = pend0_q;
    pend1_d    = pend1_q;
    pend_cnt_d = pend_cnt_q;
    if (pend_pop) begin
      pend0_d    = pend1_q;
      pend_cnt_d = pend_cnt_q - 2'd1;
    end
    if (pend_push) begin
      if (pend_cnt_d == 2'd0) pend0_d = dest_q;
      else                    pend1_d = dest_q;
      pend_cnt_d = pend_cnt_d + 2'd1;
    end
  end

  // FIFO occupancy and sticky protocol-error flag
  always_comb begin
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(issue);
    err_d      = err_q ||
                 (disp_finished_in && (state_q != D_BUSY)) ||
                 (coll_done_in && !pend_v0);
  end

  // FIFO storage write; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {cmd_src0_in, cmd_src1_in, cmd_dest_in};
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      state_q    <= D_IDLE;
      src0_q     <= '0;
      src1_q     <= '0;
      dest_q     <= '0;
      pend0_q    <= '0;
      pend1_q    <= '0;
      pend_cnt_q <= 2'd0;
      err_q      <= 1'b0;
    end else begin
      if (push)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (issue) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        src0_q   <= head_src0;
        src1_q   <= head_src1;
        dest_q   <= head_dest;
      end
      fifo_cnt_q <= fifo_cnt_d;
      state_q    <= state_d;
      pend0_q    <= pend0_d;
      pend1_q    <= pend1_d;
      pend_cnt_q <= pend_cnt_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready_out    = !fifo_full;
  assign start_mult_out   = (state_q == D_ISSUE);
  assign src_addr_0_out   = src0_q;
  assign src_addr_1_out   = src1_q;
  assign dest_addr_out    = dest_q;
  assign busy_out         = !fifo_empty || (state_q != D_IDLE) || pend_v0;
  assign queue_count_out  = fifo_cnt_q;
  assign hazard_stall_out = (state_q == D_IDLE) && !fifo_empty && pend_room && hazard;
  assign err_out          = err_q;

endmodule

// File: tb/tb_mpu_cmd_scheduler.sv
// Directed testbench for mpu_cmd_scheduler with hand-computed expectations.
module tb_mpu_cmd_scheduler;

  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid_in;
  logic              cmd_ready_out;
  logic [ADDR_W-1:0] cmd_src0_in, cmd_src1_in, cmd_dest_in;
  logic              start_mult_out;
  logic [ADDR_W-1:0] src_addr_0_out, src_addr_1_out, dest_addr_out;
  logic              disp_finished_in, coll_done_in;
  logic              busy_out;
  logic [2:0]        queue_count_out;
  logic              hazard_stall_out, err_out;

  int checks   = 0;
  int failures = 0;

  mpu_cmd_scheduler #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4), .PEND_DEPTH(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid_in     (cmd_valid_in),
    .cmd_ready_out    (cmd_ready_out),
    .cmd_src0_in      (cmd_src0_in),
    .cmd_src1_in      (cmd_src1_in),
    .cmd_dest_in      (cmd_dest_in),
    .start_mult_out   (start_mult_out),
    .src_addr_0_out   (src_addr_0_out),
    .src_addr_1_out   (src_addr_1_out),
    .dest_addr_out    (dest_addr_out),
    .disp_finished_in (disp_finished_in),
    .coll_done_in     (coll_done_in),
    .busy_out         (busy_out),
    .queue_count_out  (queue_count_out),
    .hazard_stall_out (hazard_stall_out),
    .err_out          (err_out)
  );

  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input int s0, input int s1, input int d);
    cmd_src0_in = ADDR_W'(s0);
    cmd_src1_in = ADDR_W'(s1);
    cmd_dest_in = ADDR_W'(d);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"}, 32'(start_mult_out), 0);
    check({tag, "_src0"},  32'(src_addr_0_out), 0);
    check({tag, "_src1"},  32'(src_addr_1_out), 0);
    check({tag, "_dest"},  32'(dest_addr_out), 0);
    check({tag, "_busy"},  32'(busy_out), 0);
    check({tag, "_count"}, 32'(queue_count_out), 0);
    check({tag, "_haz"},   32'(hazard_stall_out), 0);
    check({tag, "_err"},   32'(err_out), 0);
    check({tag, "_ready"}, 32'(cmd_ready_out), 1);
  endtask

  // Two commands back to back; the second may collide with the first's dest.
  task automatic run_pair(input string tag, input int a0, input int a1, input int a2,
                          input int b0, input int b1, input int b2, input bit haz);
    set_cmd(a0, a1, a2); cmd_valid_in = 1'b1;
    tick;
    set_cmd(b0, b1, b2);
    tick;
    cmd_valid_in = 1'b0;
    check({tag, "_startA"}, 32'(start_mult_out), 1);
    check({tag, "_destA"},  32'(dest_addr_out), 32'(a2));
    check({tag, "_cntA"},   32'(queue_count_out), 1);
    tick;
    check({tag, "_pulseA"}, 32'(start_mult_out), 0);
    tick; tick;
    disp_finished_in = 1'b1;
    tick;
    disp_finished_in = 1'b0;
    check({tag, "_haz1"},   32'(hazard_stall_out), 32'(haz));
    check({tag, "_nostart1"}, 32'(start_mult_out), 0);
    tick;
    if (haz) begin
      check({tag, "_stall2"}, 32'(start_mult_out), 0);
      coll_done_in = 1'b1;
      check({tag, "_hazC"},   32'(hazard_stall_out), 1);
      tick;
      coll_done_in = 1'b0;
      check({tag, "_hazC1"},  32'(hazard_stall_out), 0);
      check({tag, "_startC1"}, 32'(start_mult_out), 0);
      tick;
    end
    check({tag, "_startB"}, 32'(start_mult_out), 1);
    check({tag, "_src0B"},  32'(src_addr_0_out), 32'(b0));
    check({tag, "_src1B"},  32'(src_addr_1_out), 32'(b1));
    check({tag, "_destB"},  32'(dest_addr_out), 32'(b2));
    tick;
    // Finish B; without a hazard also retire A's result in the same cycle
    disp_finished_in = 1'b1;
    coll_done_in     = !haz;
    tick;
    disp_finished_in = 1'b0;
    coll_done_in     = 1'b0;
    check({tag, "_busyP"},  32'(busy_out), 1);
    coll_done_in = 1'b1;
    tick;
    coll_done_in = 1'b0;
    check({tag, "_idle"},   32'(busy_out), 0);
    check({tag, "_err"},    32'(err_out), 0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid_in = 1'b0; disp_finished_in = 1'b0; coll_done_in = 1'b0;
    set_cmd(0, 0, 0);
    tick; tick;
    rst = 1'b0;
    check_reset_outputs("rst");

    // Single command: start two cycles after acceptance, busy until collected
    set_cmd(1, 2, 3); cmd_valid_in = 1'b1;
    check("t1_ready", 32'(cmd_ready_out), 1);
    tick;
    cmd_valid_in = 1'b0;
    check("t1_cnt1",   32'(queue_count_out), 1);
    check("t1_start0", 32'(start_mult_out), 0);
    check("t1_busy",   32'(busy_out), 1);
    tick;
    check("t1_start",  32'(start_mult_out), 1);
    check("t1_src0",   32'(src_addr_0_out), 1);
    check("t1_src1",   32'(src_addr_1_out), 2);
    check("t1_dest",   32'(dest_addr_out), 3);
    check("t1_cnt0",   32'(queue_count_out), 0);
    tick;
    check("t1_pulse",  32'(start_mult_out), 0);
    check("t1_hold",   32'(dest_addr_out), 3);
    repeat (3) tick;
    check("t1_busyB",  32'(busy_out), 1);
    disp_finished_in = 1'b1;
    tick;
    disp_finished_in = 1'b0;
    check("t1_busyP",  32'(busy_out), 1);
    coll_done_in = 1'b1;
    tick;
    coll_done_in = 1'b0;
    check("t1_idle",   32'(busy_out), 0);
    check("t1_err",    32'(err_out), 0);

    // Overlap and hazard cases
    run_pair("t2_nohaz", 1, 2, 3, 4, 5, 6, 1'b0);
    run_pair("t2_near",  1, 2, 3, 2, 1, 4, 1'b0);
    run_pair("t3_raw0",  1, 2, 3, 3, 5, 6, 1'b1);
    run_pair("t3_raw1",  1, 2, 3, 0, 3, 6, 1'b1);
    run_pair("t3_waw",   1, 2, 3, 7, 0, 3, 1'b1);

    // Protocol errors are sticky and do not disturb state
    coll_done_in = 1'b1;
    tick;
    coll_done_in = 1'b0;
    check("t5_err1",  32'(err_out), 1);
    check("t5_busy1", 32'(busy_out), 0);
    disp_finished_in = 1'b1;
    tick;
    disp_finished_in = 1'b0;
    check("t5_err2",  32'(err_out), 1);
    check("t5_start", 32'(start_mult_out), 0);
    check("t5_busy2", 32'(busy_out), 0);
    check("t5_cnt",   32'(queue_count_out), 0);
    tick; tick;
    check("t5_sticky", 32'(err_out), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("t5_clr",   32'(err_out), 0);

    // FIFO fill while dispatch is busy
    set_cmd(1, 1, 1); cmd_valid_in = 1'b1;
    tick;
    cmd_valid_in = 1'b0;
    tick;
    check("t4_start0", 32'(start_mult_out), 1);
    tick;
    for (int i = 0; i < 5; i++) begin
      set_cmd(i + 2, i + 2, i + 2); cmd_valid_in = 1'b1;
      check($sformatf("t4_ready%0d", i), 32'(cmd_ready_out), (i < 4) ? 1 : 0);
      tick;
    end
    check("t4_cnt4",   32'(queue_count_out), 4);
    check("t4_full",   32'(cmd_ready_out), 0);
    check("t4_nost",   32'(start_mult_out), 0);
    disp_finished_in = 1'b1;
    tick;
    disp_finished_in = 1'b0;
    // Head pops this cycle, but a full FIFO still refuses the push
    check("t4_cntM1",  32'(queue_count_out), 4);
    check("t4_rdyM1",  32'(cmd_ready_out), 0);
    check("t4_hazM1",  32'(hazard_stall_out), 0);
    tick;
    check("t4_startM2", 32'(start_mult_out), 1);
    check("t4_src0M2",  32'(src_addr_0_out), 2);
    check("t4_cntM2",   32'(queue_count_out), 3);
    check("t4_rdyM2",   32'(cmd_ready_out), 1);
    tick;
    cmd_valid_in = 1'b0;
    check("t4_cntM3",   32'(queue_count_out), 4);
    check("t4_rdyM3",   32'(cmd_ready_out), 0);

    // Reset during busy dispatch with commands queued
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_reset_outputs("t6");
    for (int i = 0; i < 5; i++) begin
      tick;
      check($sformatf("t6_nostart%0d", i), 32'(start_mult_out), 0);
      check($sformatf("t6_cnt%0d", i),     32'(queue_count_out), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
